packet_scheduler: RTL and testbench

//  Data-island packet scheduler for the HDMI TX path. Collects requests from the ACR, audio

---
 rtl/packet_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_packet_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// ---------------------------------------------------------------------------
// packet_scheduler
//
// Data-island packet scheduler for the HDMI TX path. Requests from the audio
// sample, ACR, AVI InfoFrame and Audio InfoFrame generators are collected as
// pending work. At every packet slot offered by the timing core, one packet
// (header + four subpackets) is registered for the packet assembler. Idle
// slots are filled with a null packet. One AVI/Audio InfoFrame pair is
// scheduled every INFOFRAME_PERIOD frames.
//
// Optional feature macro: PACKET_SCHED_STATS_EN
//   When defined, adds the miss_cnt and drop_cnt statistics ports.
//
// Parameters
//   INFOFRAME_PERIOD  frames between InfoFrame schedules (1..255)
//   AUDIO_DEPTH       max queued audio sample requests (2..15)
//   PACKET_CYCLES     cycles a packet occupies the assembler (>=2)
//
// Ports
//   clk_pixel     in   pixel clock, all logic on rising edge
//   reset_n       in   synchronous active-low reset
//   frame_start   in   1-cycle pulse, first pixel of frame
//   packet_slot   in   1-cycle pulse, assembler can accept next packet
//   audio_req     in   1-cycle pulse, one audio sample packet ready
//   acr_req       in   1-cycle pulse, ACR packet ready
//   src_header    in   4x24 headers, 0=audio 1=ACR 2=AVI 3=AudioIF
//   src_sub       in   4x224 subpackets {sub3,sub2,sub1,sub0}, same indexing
//   header_out    out  registered packet header
//   sub_out       out  registered subpackets
//   packet_valid  out  high for PACKET_CYCLES cycles per issued packet
//   grant         out  one-hot pulse naming the source captured (0 = null)
//   overrun       out  sticky, packet_slot seen while a packet is in flight
//   miss_cnt      out  (stats only) InfoFrame schedules that found work pending
//   drop_cnt      out  (stats only) audio requests dropped at saturation
// ---------------------------------------------------------------------------
module packet_scheduler #(
    parameter int INFOFRAME_PERIOD = 1,
    parameter int AUDIO_DEPTH      = 4,
    parameter int PACKET_CYCLES    = 32
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               packet_slot,
    input  logic               audio_req,
    input  logic               acr_req,
    input  logic [3:0][23:0]   src_header,
    input  logic [3:0][223:0]  src_sub,
    output logic [23:0]        header_out,
    output logic [223:0]       sub_out,
    output logic               packet_valid,
    output logic [3:0]         grant,
    output logic               overrun
`ifdef PACKET_SCHED_STATS_EN
    ,
    output logic [15:0]        miss_cnt,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int CNT_W = (PACKET_CYCLES > 2) ? $clog2(PACKET_CYCLES) : 1;
    localparam int AUD_W = 4;
    localparam int FRM_W = 8;

    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(PACKET_CYCLES - 2);
    localparam logic [AUD_W-1:0] AUD_MAX    = AUD_W'(AUDIO_DEPTH);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(INFOFRAME_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  busy_cnt;

    logic [AUD_W-1:0]  audio_cnt;
    logic              acr_pend;
    logic              avi_pend;
    logic              aif_pend;
    logic [FRM_W-1:0]  frame_cnt;

    logic              accept;
    logic              slot_overrun;
    logic [3:0]        sel;
    logic [3:0]        take;
    logic [23:0]       cap_header;
    logic [223:0]      cap_sub;

    logic [AUD_W-1:0]  aud_after_take;
    logic              aud_add;
    logic              aud_drop;
    logic              sched;

    // State register plus the BUSY dwell counter. The counter restarts at
    // zero on entry to BUSY, so BUSY lasts PACKET_CYCLES-1 cycles and,
    // together with the single LOAD cycle, packet_valid is high for exactly
    // PACKET_CYCLES cycles.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end else begin
                busy_cnt <= '0;
            end
        end
    end

    // Next-state logic. A slot is only accepted in IDLE; any slot that
    // arrives while a packet is in flight is flagged as an overrun.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        slot_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (packet_slot) begin
                    state_next = LOAD;
                    accept     = 1'b1;
                end
            end
            LOAD: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (busy_cnt == BUSY_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (packet_slot && (state != IDLE)) begin
            slot_overrun = 1'b1;
        end
    end

    // Fixed priority audio > ACR > AVI > AudioIF; an empty selection means
    // the slot is filled with the all-zero null packet.
    always_comb begin
        sel        = 4'b0000;
        cap_header = '0;
        cap_sub    = '0;
        if (audio_cnt != '0) begin
            sel        = 4'b0001;
            cap_header = src_header[0];
            cap_sub    = src_sub[0];
        end else if (acr_pend) begin
            sel        = 4'b0010;
            cap_header = src_header[1];
            cap_sub    = src_sub[1];
        end else if (avi_pend) begin
            sel        = 4'b0100;
            cap_header = src_header[2];
            cap_sub    = src_sub[2];
        end else if (aif_pend) begin
            sel        = 4'b1000;
            cap_header = src_header[3];
            cap_sub    = src_sub[3];
        end
        take = accept ? sel : 4'b0000;
    end

    // Audio occupancy is judged after removing the sample granted on this
    // edge, so a request coinciding with a grant at full depth is kept.
    // InfoFrames are scheduled by the frame_start that finds the frame
    // counter at zero, which includes the first frame after reset.
    always_comb begin
        aud_after_take = audio_cnt - AUD_W'(take[0]);
        aud_add        = audio_req && (aud_after_take < AUD_MAX);
        aud_drop       = audio_req && !aud_add;
        sched          = frame_start && (frame_cnt == '0);
    end

    // Pending work. A set in the same cycle as a grant wins over the clear,
    // so a coincident request is never lost.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            audio_cnt <= '0;
            acr_pend  <= 1'b0;
            avi_pend  <= 1'b0;
            aif_pend  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            audio_cnt <= aud_after_take + AUD_W'(aud_add);
            acr_pend  <= acr_req | (acr_pend & ~take[1]);
            avi_pend  <= sched   | (avi_pend & ~take[2]);
            aif_pend  <= sched   | (aif_pend & ~take[3]);
            if (frame_start) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FRM_W'(1);
            end
        end
    end

    // Packet capture and the one-cycle grant pulse. Header and subpackets
    // hold their value until the next accepted slot.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            header_out <= '0;
            sub_out    <= '0;
            grant      <= 4'b0000;
            overrun    <= 1'b0;
        end else begin
            grant <= take;
            if (accept) begin
                header_out <= cap_header;
                sub_out    <= cap_sub;
            end
            if (slot_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

    assign packet_valid = (state == LOAD) || (state == BUSY);

`ifdef PACKET_SCHED_STATS_EN
    logic miss_event;

    // A miss is an InfoFrame schedule that arrives while a previous one is
    // still waiting and is not being granted on this very edge.
    assign miss_event = sched && ((avi_pend && !take[2]) || (aif_pend && !take[3]));

    // Saturating statistics counters.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (miss_event && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (aud_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = aud_drop;
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_packet_scheduler
//
// Self-checking bench for packet_scheduler (INFOFRAME_PERIOD=3, AUDIO_DEPTH=4,
// PACKET_CYCLES=32). A queue-free behavioural model tracks pending work as
// plain integers and flags and is compared against the DUT on every falling
// edge; directed literal checks pin the expected grant sequences.
// Define PACKET_SCHED_STATS_EN to also check the statistics ports.
// ---------------------------------------------------------------------------
module tb_packet_scheduler;

    localparam int PERIOD = 3;
    localparam int DEPTH  = 4;
    localparam int PCYC   = 32;

    logic               clk_pixel = 1'b0;
    logic               reset_n;
    logic               frame_start;
    logic               packet_slot;
    logic               audio_req;
    logic               acr_req;
    logic [3:0][23:0]   src_header;
    logic [3:0][223:0]  src_sub;
    logic [23:0]        header_out;
    logic [223:0]       sub_out;
    logic               packet_valid;
    logic [3:0]         grant;
    logic               overrun;
`ifdef PACKET_SCHED_STATS_EN
    logic [15:0]        miss_cnt;
    logic [15:0]        drop_cnt;
`endif

    int checks = 0;
    int passes = 0;

    packet_scheduler #(
        .INFOFRAME_PERIOD (PERIOD),
        .AUDIO_DEPTH      (DEPTH),
        .PACKET_CYCLES    (PCYC)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .packet_slot  (packet_slot),
        .audio_req    (audio_req),
        .acr_req      (acr_req),
        .src_header   (src_header),
        .src_sub      (src_sub),
        .header_out   (header_out),
        .sub_out      (sub_out),
        .packet_valid (packet_valid),
        .grant        (grant),
        .overrun      (overrun)
`ifdef PACKET_SCHED_STATS_EN
        ,
        .miss_cnt     (miss_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    // Compare one DUT value against its expectation and keep the tallies.
    task automatic checkOutput(input string name, input logic [223:0] actual,
                               input logic [223:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: pending work as counts and flags, the packet in
    // flight as the number of cycles it still occupies the assembler.
    int              m_audio;
    int              m_frame;
    int              m_remaining;
    int              m_miss;
    int              m_drop;
    bit              m_acr;
    bit              m_avi;
    bit              m_aif;
    bit              m_overrun;
    bit              m_started = 1'b0;
    logic [23:0]     m_header;
    logic [223:0]    m_sub;
    logic [3:0]      m_grant;

    always @(posedge clk_pixel) begin
        int src;
        bit busy;
        m_started = 1'b1;
        if (!reset_n) begin
            m_audio = 0; m_frame = 0; m_remaining = 0; m_miss = 0; m_drop = 0;
            m_acr = 0; m_avi = 0; m_aif = 0; m_overrun = 0;
            m_header = '0; m_sub = '0; m_grant = '0;
        end else begin
            busy    = (m_remaining > 0);
            src     = -1;
            m_grant = 4'b0000;
            if (packet_slot && !busy) begin
                if (m_audio > 0)  src = 0;
                else if (m_acr)   src = 1;
                else if (m_avi)   src = 2;
                else if (m_aif)   src = 3;
                if (src >= 0) begin
                    m_header = src_header[src];
                    m_sub    = src_sub[src];
                    m_grant  = 4'b0001 << src;
                end else begin
                    m_header = '0;
                    m_sub    = '0;
                end
                m_remaining = PCYC;
            end else begin
                if (packet_slot) m_overrun = 1'b1;
                if (busy) m_remaining--;
            end
            if (src == 0) m_audio--;
            if (src == 1) m_acr = 1'b0;
            if (src == 2) m_avi = 1'b0;
            if (src == 3) m_aif = 1'b0;
            if (audio_req) begin
                if (m_audio < DEPTH) m_audio++;
                else if (m_drop < 65535) m_drop++;
            end
            if (acr_req) m_acr = 1'b1;
            if (frame_start) begin
                if (m_frame == 0) begin
                    if ((m_avi || m_aif) && m_miss < 65535) m_miss++;
                    m_avi = 1'b1;
                    m_aif = 1'b1;
                end
                m_frame = (m_frame + 1) % PERIOD;
            end
        end
    end

    // Every falling edge: all outputs must agree with the model.
    always @(negedge clk_pixel) begin
        if (m_started) begin
            checkOutput("model.header", 224'(header_out), 224'(m_header));
            checkOutput("model.sub", sub_out, m_sub);
            checkOutput("model.valid", 224'(packet_valid), 224'(m_remaining > 0));
            checkOutput("model.grant", 224'(grant), 224'(m_grant));
            checkOutput("model.overrun", 224'(overrun), 224'(m_overrun));
`ifdef PACKET_SCHED_STATS_EN
            checkOutput("model.miss_cnt", 224'(miss_cnt), 224'(m_miss));
            checkOutput("model.drop_cnt", 224'(drop_cnt), 224'(m_drop));
`endif
        end
    end

    // Drive one cycle of pulses, then return on the next falling edge with
    // the pulses cleared; registered effects are visible on return.
    task automatic applyStimulus(input bit fs, input bit slot, input bit areq, input bit acr);
        frame_start = fs;
        packet_slot = slot;
        audio_req   = areq;
        acr_req     = acr;
        @(negedge clk_pixel);
        frame_start = 1'b0;
        packet_slot = 1'b0;
        audio_req   = 1'b0;
        acr_req     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    // Slot followed by a literal grant check, then wait out the packet.
    task automatic slotAndCheck(input string name, input logic [3:0] exp_grant);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput(name, 224'(grant), 224'(exp_grant));
        idle(39);
    endtask

    logic [3:0] frame_grants [6];
    int         audio_grants;

    initial begin
        frame_grants[0] = 4'b0100; frame_grants[1] = 4'b1000; frame_grants[2] = 4'b0000;
        frame_grants[3] = 4'b0100; frame_grants[4] = 4'b1000; frame_grants[5] = 4'b0000;
        src_header[0] = 24'h000002;
        src_header[1] = 24'h000001;
        src_header[2] = 24'h0D0282;
        src_header[3] = 24'h0A0184;
        for (int i = 0; i < 4; i++) begin
            src_sub[i] = {7{32'hC0DE0000 | 32'(i + 1)}};
        end
        reset_n     = 1'b0;
        frame_start = 1'b0;
        packet_slot = 1'b0;
        audio_req   = 1'b0;
        acr_req     = 1'b0;

        // Reset state
        idle(3);
        checkOutput("reset.valid", 224'(packet_valid), 224'(0));
        checkOutput("reset.grant", 224'(grant), 224'(0));
        checkOutput("reset.header", 224'(header_out), 224'(0));
        checkOutput("reset.overrun", 224'(overrun), 224'(0));
        reset_n = 1'b1;

        // Null packet with nothing pending; valid for exactly 32 cycles
        $display("[TB] null packet");
        idle(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("null.grant", 224'(grant), 224'(0));
        checkOutput("null.header", 224'(header_out), 224'(0));
        checkOutput("null.valid_first", 224'(packet_valid), 224'(1));
        idle(31);
        checkOutput("null.valid_last", 224'(packet_valid), 224'(1));
        idle(1);
        checkOutput("null.valid_after", 224'(packet_valid), 224'(0));
        idle(8);

        // Priority order across all four sources
        $display("[TB] priority");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("prio.grant0", 224'(grant), 224'(4'b0001));
        checkOutput("prio.header0", 224'(header_out), 224'(24'h000002));
        idle(39);
        slotAndCheck("prio.grant1", 4'b0010);
        checkOutput("prio.header1_hold", 224'(header_out), 224'(24'h000001));
        slotAndCheck("prio.grant2", 4'b0100);
        slotAndCheck("prio.grant3", 4'b1000);
        checkOutput("prio.sub3_hold", sub_out, {7{32'hC0DE0004}});
        slotAndCheck("prio.grant4", 4'b0000);

        // Audio saturation: six requests, four served
        $display("[TB] audio saturation");
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PACKET_SCHED_STATS_EN
        checkOutput("sat.drop_cnt", 224'(drop_cnt), 224'(2));
`endif
        audio_grants = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (grant == 4'b0001) audio_grants++;
            idle(39);
        end
        checkOutput("sat.audio_grants", 224'(audio_grants), 224'(4));

        // Slot while busy is ignored and flagged
        $display("[TB] overrun");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr.first_grant", 224'(grant), 224'(4'b0001));
        idle(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr.ignored_grant", 224'(grant), 224'(0));
        checkOutput("ovr.flag", 224'(overrun), 224'(1));
        checkOutput("ovr.header_kept", 224'(header_out), 224'(24'h000002));
        idle(40);
        slotAndCheck("ovr.next_grant", 4'b0010);

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        reset_n = 1'b0;
        idle(1);
        checkOutput("rst.valid", 224'(packet_valid), 224'(0));
        checkOutput("rst.grant", 224'(grant), 224'(0));
        checkOutput("rst.header", 224'(header_out), 224'(0));
        checkOutput("rst.overrun", 224'(overrun), 224'(0));
        reset_n = 1'b1;
        idle(1);
        slotAndCheck("rst.pend_cleared", 4'b0000);

        // InfoFrames only on frames 0 and 3 of six
        $display("[TB] infoframe period");
        for (int f = 0; f < 6; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("period.frame%0d", f), 224'(grant), 224'(frame_grants[f]));
            idle(38);
        end

        // frame_start coinciding with the AVI grant keeps AVI pending
        $display("[TB] coincident set and grant");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("coin.avi_first", 224'(grant), 224'(4'b0100));
        idle(39);
        slotAndCheck("coin.avi_again", 4'b0100);
        slotAndCheck("coin.aif", 4'b1000);
        slotAndCheck("coin.empty", 4'b0000);

        // Audio request coinciding with its own grant is not lost
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("coin.audio_first", 224'(grant), 224'(4'b0001));
        idle(39);
        slotAndCheck("coin.audio_kept", 4'b0001);
        slotAndCheck("coin.audio_empty", 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
